vga_sync_gen: RTL and testbench

//  Parametrised VGA timing generator: divides clk into a pixel-enable tick and drives

---
 rtl/vga_sync_gen.sv | 135 +++++++++++++
 tb/tb_vga_sync_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : Parametrised VGA timing generator. Divides clk into a one-cycle
//            pixel-enable tick and drives horizontal/vertical counters, sync
//            pulses, video_on and line/frame strobes. All decoded outputs are
//            registered from the next-state counters so they line up with
//            h_count/v_count with zero skew.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   CLK_DIV   = 4,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_start
);

  localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_DW-1:0] c_DIV_MAX  = c_DW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   c_H_MAX    = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0]   c_V_MAX    = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0]   c_H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0]   c_V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0]   c_HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0]   c_HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0]   c_VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0]   c_VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [c_DW-1:0] r_div_cnt;
  logic            r_p_tick;
  logic [CW-1:0]   r_h_count;
  logic [CW-1:0]   r_v_count;
  logic            r_video_on;
  logic            r_h_sync;
  logic            r_v_sync;
  logic            r_at_line_end;
  logic            r_at_origin;

  logic [c_DW-1:0] w_div_next;
  logic            w_tick;
  logic [CW-1:0]   w_h_next;
  logic [CW-1:0]   w_v_next;

  // r_p_tick mirrors (div_cnt == CLK_DIV-1); gating with en freezes the tick
  // in the same cycle en drops, so no pixel is skipped or repeated.
  assign w_tick = en & r_p_tick;

  // Divider next state: advance only while enabled, wrap at CLK_DIV-1.
  always_comb begin
    w_div_next = r_div_cnt;
    if (en) begin
      w_div_next = (r_div_cnt == c_DIV_MAX) ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Counter next state: h advances on each tick, v advances when h wraps.
  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (w_tick) begin
      if (r_h_count == c_H_MAX) begin
        w_h_next = '0;
        w_v_next = (r_v_count == c_V_MAX) ? '0 : r_v_count + 1'b1;
      end else begin
        w_h_next = r_h_count + 1'b1;
      end
    end
  end

  // Divider, tick flag and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_p_tick  <= 1'b0;
      r_h_count <= '0;
      r_v_count <= '0;
    end else begin
      r_div_cnt <= w_div_next;
      r_p_tick  <= (w_div_next == c_DIV_MAX);
      r_h_count <= w_h_next;
      r_v_count <= w_v_next;
    end
  end

  // Decode registered from next-state counters so it matches h/v with no skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_video_on    <= 1'b0;
      r_h_sync      <= ~HS_POL;
      r_v_sync      <= ~VS_POL;
      r_at_line_end <= 1'b0;
      r_at_origin   <= 1'b0;
    end else begin
      r_video_on    <= (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
      r_h_sync      <= ((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST)) ? HS_POL : ~HS_POL;
      r_v_sync      <= ((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST)) ? VS_POL : ~VS_POL;
      r_at_line_end <= (w_h_next == c_H_MAX);
      r_at_origin   <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign p_tick      = w_tick;
  assign h_count     = r_h_count;
  assign v_count     = r_v_count;
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign video_on    = r_video_on;
  assign line_end    = w_tick & r_at_line_end;
  assign frame_start = w_tick & r_at_origin;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Self-checking bench for vga_sync_gen. Three instances: default
//            640x480 timing, a tiny geometry for whole-frame behaviour, and a
//            CLK_DIV=1 / HS_POL=1 / H_DISPLAY=320 variant. Expected tick
//            records are queued by the stimulus; per-instance monitors pop and
//            compare them whenever that instance presents a p_tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct {
    int idx;
    int gap;
    int h;
    int v;
    int hs;
    int vs;
    int von;
    int le;
    int fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, en_a = 1'b1;
  logic rst_bc = 1'b1, en_bc = 1'b1;
  logic rq_a = 1'b1, rq_bc = 1'b1;

  logic       p_tick_a, hs_a, vs_a, von_a, le_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       p_tick_b, hs_b, vs_b, von_b, le_b, fs_b;
  logic [5:0] h_b, v_b;
  logic       p_tick_c, hs_c, vs_c, von_c, le_c, fs_c;
  logic [9:0] h_c, v_c;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;
  int idx_a = 0, cnt_a = 0, gap_a = 0;
  int idx_b = 0, cnt_b = 0, gap_b = 0;
  int idx_c = 0, cnt_c = 0, gap_c = 0;
  int le_cnt_b = 0, fs_cnt_b = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .p_tick(p_tick_a), .h_count(h_a), .v_count(v_a),
    .h_sync(hs_a), .v_sync(vs_a), .video_on(von_a), .line_end(le_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(3), .CW(6)
  ) u_b (
    .clk(clk), .rst(rst_bc), .en(en_bc), .p_tick(p_tick_b), .h_count(h_b), .v_count(v_b),
    .h_sync(hs_b), .v_sync(vs_b), .video_on(von_b), .line_end(le_b), .frame_start(fs_b)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HS_POL(1'b1), .H_DISPLAY(320)
  ) u_c (
    .clk(clk), .rst(rst_bc), .en(en_bc), .p_tick(p_tick_c), .h_count(h_c), .v_count(v_c),
    .h_sync(hs_c), .v_sync(vs_c), .video_on(von_c), .line_end(le_c), .frame_start(fs_c)
  );

  // Reset as seen by the DUTs at the most recent edge.
  always @(posedge clk) begin
    rq_a  <= rst_a;
    rq_bc <= rst_bc;
  end

  function automatic exp_t mk(int idx, int gap, int h, int v, int hs, int vs, int von, int le, int fs);
    exp_t e;
    e.idx = idx; e.gap = gap; e.h = h; e.v = v;
    e.hs = hs; e.vs = vs; e.von = von; e.le = le; e.fs = fs;
    return e;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void cmp_tick(string tag, int idx, exp_t e, logic [31:0] h, logic [31:0] v,
                                   logic hs, logic vs, logic von, logic le, logic fs);
    chk($sformatf("%s tick%0d h_count", tag, idx), h, e.h);
    chk($sformatf("%s tick%0d v_count", tag, idx), v, e.v);
    chk($sformatf("%s tick%0d h_sync", tag, idx), 32'(hs), e.hs);
    chk($sformatf("%s tick%0d v_sync", tag, idx), 32'(vs), e.vs);
    chk($sformatf("%s tick%0d video_on", tag, idx), 32'(von), e.von);
    chk($sformatf("%s tick%0d line_end", tag, idx), 32'(le), e.le);
    chk($sformatf("%s tick%0d frame_start", tag, idx), 32'(fs), e.fs);
  endfunction

  // Monitor A: default timing, first tick 3 clks after reset, then every 4.
  always @(negedge clk) begin
    if (rq_a) begin
      chk("A p_tick during reset", 32'(p_tick_a), 0);
      idx_a = 0; cnt_a = 0;
    end else begin
      cnt_a++;
      chk("A strobe without p_tick", 32'((le_a | fs_a) & ~p_tick_a), 0);
      if (p_tick_a) begin
        gap_a = (idx_a == 0) ? 3 : 4;
        if (q_a.size() > 0 && q_a[0].idx == idx_a) begin
          e_a = q_a.pop_front();
          if (e_a.gap != 0) gap_a = e_a.gap;
          cmp_tick("A", idx_a, e_a, 32'(h_a), 32'(v_a), hs_a, vs_a, von_a, le_a, fs_a);
        end
        chk($sformatf("A tick%0d gap", idx_a), cnt_a, gap_a);
        cnt_a = 0; idx_a++;
      end
    end
  end

  // Monitor B: tiny geometry, CLK_DIV=3; also tallies strobes over frame 0.
  always @(negedge clk) begin
    if (rq_bc) begin
      idx_b = 0; cnt_b = 0;
    end else begin
      cnt_b++;
      chk("B strobe without p_tick", 32'((le_b | fs_b) & ~p_tick_b), 0);
      if (p_tick_b) begin
        gap_b = (idx_b == 0) ? 2 : 3;
        if (idx_b < 240) begin
          le_cnt_b += int'(le_b);
          fs_cnt_b += int'(fs_b);
        end
        if (q_b.size() > 0 && q_b[0].idx == idx_b) begin
          e_b = q_b.pop_front();
          cmp_tick("B", idx_b, e_b, 32'(h_b), 32'(v_b), hs_b, vs_b, von_b, le_b, fs_b);
        end
        chk($sformatf("B tick%0d gap", idx_b), cnt_b, gap_b);
        cnt_b = 0; idx_b++;
      end
    end
  end

  // Monitor C: CLK_DIV=1, so every tick must follow the previous by one clk.
  always @(negedge clk) begin
    if (rq_bc) begin
      chk("C p_tick during reset", 32'(p_tick_c), 0);
      idx_c = 0; cnt_c = 0;
    end else begin
      cnt_c++;
      if (p_tick_c) begin
        gap_c = 1;
        if (q_c.size() > 0 && q_c[0].idx == idx_c) begin
          e_c = q_c.pop_front();
          cmp_tick("C", idx_c, e_c, 32'(h_c), 32'(v_c), hs_c, vs_c, von_c, le_c, fs_c);
        end
        chk($sformatf("C tick%0d gap", idx_c), cnt_c, gap_c);
        cnt_c = 0; idx_c++;
      end else if (idx_c < 600) begin
        chk($sformatf("C p_tick held high after tick%0d", idx_c), 32'(p_tick_c), 1);
      end
    end
  end

  task automatic wait_tick_a(input int h, input int v, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (p_tick_a && int'(h_a) == h && int'(v_a) == v) found = 1'b1;
    end
    chk($sformatf("A reached tick at h%0d v%0d", h, v), 32'(found), 1);
  endtask

  initial begin
    // A: idx, gap(0=nominal), h, v, hs, vs, von, le, fs
    q_a.push_back(mk(0,    0,   0, 0, 1, 1, 1, 0, 1));
    q_a.push_back(mk(1,    0,   1, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(639,  0, 639, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(640,  0, 640, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(655,  0, 655, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(656,  0, 656, 0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(751,  0, 751, 0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(752,  0, 752, 0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(799,  0, 799, 0, 1, 1, 0, 1, 0));
    q_a.push_back(mk(800,  0,   0, 1, 1, 1, 1, 0, 0));
    q_a.push_back(mk(1099, 0, 299, 1, 1, 1, 1, 0, 0));
    q_a.push_back(mk(1100, 41, 300, 1, 1, 1, 1, 0, 0));
    q_a.push_back(mk(1101, 0, 301, 1, 1, 1, 1, 0, 0));
    q_a.push_back(mk(1599, 0, 799, 1, 1, 1, 0, 1, 0));
    q_a.push_back(mk(1600, 0,   0, 2, 1, 1, 1, 0, 0));
    // B: H_TOTAL 24 (hs 18..20), V_TOTAL 10 (vs 7..8), visible 16x6
    q_b.push_back(mk(0,   0,  0, 0, 1, 1, 1, 0, 1));
    q_b.push_back(mk(15,  0, 15, 0, 1, 1, 1, 0, 0));
    q_b.push_back(mk(16,  0, 16, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(17,  0, 17, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(18,  0, 18, 0, 0, 1, 0, 0, 0));
    q_b.push_back(mk(20,  0, 20, 0, 0, 1, 0, 0, 0));
    q_b.push_back(mk(21,  0, 21, 0, 1, 1, 0, 0, 0));
    q_b.push_back(mk(23,  0, 23, 0, 1, 1, 0, 1, 0));
    q_b.push_back(mk(24,  0,  0, 1, 1, 1, 1, 0, 0));
    q_b.push_back(mk(143, 0, 23, 5, 1, 1, 0, 1, 0));
    q_b.push_back(mk(144, 0,  0, 6, 1, 1, 0, 0, 0));
    q_b.push_back(mk(167, 0, 23, 6, 1, 1, 0, 1, 0));
    q_b.push_back(mk(168, 0,  0, 7, 1, 0, 0, 0, 0));
    q_b.push_back(mk(191, 0, 23, 7, 1, 0, 0, 1, 0));
    q_b.push_back(mk(192, 0,  0, 8, 1, 0, 0, 0, 0));
    q_b.push_back(mk(216, 0,  0, 9, 1, 1, 0, 0, 0));
    q_b.push_back(mk(239, 0, 23, 9, 1, 1, 0, 1, 0));
    q_b.push_back(mk(240, 0,  0, 0, 1, 1, 1, 0, 1));
    q_b.push_back(mk(264, 0,  0, 1, 1, 1, 1, 0, 0));
    // C: H_TOTAL 480, h_sync active-high for 336..431
    q_c.push_back(mk(0,   0,   0, 0, 0, 1, 1, 0, 1));
    q_c.push_back(mk(319, 0, 319, 0, 0, 1, 1, 0, 0));
    q_c.push_back(mk(320, 0, 320, 0, 0, 1, 0, 0, 0));
    q_c.push_back(mk(335, 0, 335, 0, 0, 1, 0, 0, 0));
    q_c.push_back(mk(336, 0, 336, 0, 1, 1, 0, 0, 0));
    q_c.push_back(mk(431, 0, 431, 0, 1, 1, 0, 0, 0));
    q_c.push_back(mk(432, 0, 432, 0, 0, 1, 0, 0, 0));
    q_c.push_back(mk(479, 0, 479, 0, 0, 1, 0, 1, 0));
    q_c.push_back(mk(480, 0,   0, 1, 0, 1, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("A reset h_count", 32'(h_a), 0);
    chk("A reset v_count", 32'(v_a), 0);
    chk("A reset h_sync", 32'(hs_a), 1);
    chk("A reset v_sync", 32'(vs_a), 1);
    chk("A reset video_on", 32'(von_a), 0);
    chk("A reset line_end", 32'(le_a), 0);
    chk("A reset frame_start", 32'(fs_a), 0);
    chk("C reset h_sync", 32'(hs_c), 0);
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    @(posedge clk); #1;
    chk("A video_on first clk after reset", 32'(von_a), 1);
    chk("A h_sync first clk after reset", 32'(hs_a), 1);

    // Freeze mid-line with h at 300 for 37 clks.
    wait_tick_a(299, 1, 6000);
    @(posedge clk); #1 en_a = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    chk("A frozen h_count", 32'(h_a), 300);
    chk("A frozen v_count", 32'(v_a), 1);
    chk("A frozen p_tick", 32'(p_tick_a), 0);
    chk("A frozen video_on", 32'(von_a), 1);
    en_a = 1'b1;

    // Reset pulse while inside h_sync (h=700).
    wait_tick_a(699, 2, 6000);
    @(posedge clk); #1 rst_a = 1'b1;
    chk("A h_count before reset edge", 32'(h_a), 700);
    chk("A h_sync before reset edge", 32'(hs_a), 0);
    q_a.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1));
    q_a.push_back(mk(1, 0, 1, 0, 1, 1, 1, 0, 0));
    @(posedge clk); #1 rst_a = 1'b0;
    chk("A mid-frame reset h_count", 32'(h_a), 0);
    chk("A mid-frame reset v_count", 32'(v_a), 0);
    chk("A mid-frame reset h_sync", 32'(hs_a), 1);
    chk("A mid-frame reset v_sync", 32'(vs_a), 1);
    chk("A mid-frame reset video_on", 32'(von_a), 0);
    chk("A mid-frame reset p_tick", 32'(p_tick_a), 0);
    @(posedge clk); #1;
    chk("A video_on one clk after reset", 32'(von_a), 1);
    chk("A h_count one clk after reset", 32'(h_a), 0);

    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("A expected ticks outstanding", q_a.size(), 0);
    chk("B expected ticks outstanding", q_b.size(), 0);
    chk("C expected ticks outstanding", q_c.size(), 0);
    chk("B line_end per frame", le_cnt_b, 10);
    chk("B frame_start per frame", fs_cnt_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
